// File: rtl/mmio_router.sv
// mmio_router
// Single-master memory-mapped I/O router. Decodes the CPU byte address
// against a table of base/size windows, drives a one-hot req/ack handshake
// to the selected target and reports unmapped, timeout and target-error
// faults.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access; ce=0 latches the request and decodes the address
// REQ   | t_req[sel] high, waiting for t_ack/t_err or timeout
// DONE  | access complete without fault, held until ce=1
// FAULT | access faulted (fault_cause valid), held until ce=1
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ce                    access enable, active low
//   funct3, addr, datain  access size/sign, byte address, write data
//   memwrite              1 = store, 0 = load
//   dataout               registered load data
//   busy, valid, done     access status
//   access_fault          access faulted
//   fault_cause           0 none, 1 unmapped, 2 timeout, 3 target error
//   fault_addr            address of the most recent faulting access
//   t_req                 one-hot target request
//   t_addr                offset within the selected window
//   t_wdata, t_write      registered write data / direction
//   t_funct3              registered funct3
//   t_ack, t_err          per-target completion / error
//   t_rdata               packed per-target read data
module mmio_router #(
    parameter int                        N_TARGETS      = 4,
    parameter int                        DATA_W         = 32,
    parameter logic [N_TARGETS*32-1:0]   BASE_ADDRS     = {32'h0080_0080, 32'h0080_0040,
                                                           32'h0080_0000, 32'h0000_0000},
    parameter logic [N_TARGETS*5-1:0]    SIZE_LOG2      = {5'd6, 5'd6, 5'd6, 5'd23},
    parameter int                        TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ce,
    input  logic [2:0]                    funct3,
    input  logic [31:0]                   addr,
    input  logic [DATA_W-1:0]             datain,
    input  logic                          memwrite,
    output logic [DATA_W-1:0]             dataout,
    output logic                          busy,
    output logic                          valid,
    output logic                          done,
    output logic                          access_fault,
    output logic [1:0]                    fault_cause,
    output logic [31:0]                   fault_addr,
    output logic [N_TARGETS-1:0]          t_req,
    output logic [31:0]                   t_addr,
    output logic [DATA_W-1:0]             t_wdata,
    output logic                          t_write,
    output logic [2:0]                    t_funct3,
    input  logic [N_TARGETS-1:0]          t_ack,
    input  logic [N_TARGETS-1:0]          t_err,
    input  logic [N_TARGETS*DATA_W-1:0]   t_rdata
);

    localparam int SEL_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_TGT_ERR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         t_addr_q, t_addr_d;
    logic [DATA_W-1:0]   t_wdata_q, t_wdata_d;
    logic                t_write_q, t_write_d;
    logic [2:0]          t_funct3_q, t_funct3_d;
    logic [DATA_W-1:0]   dataout_q, dataout_d;
    logic [1:0]          fault_cause_q, fault_cause_d;
    logic [31:0]         fault_addr_q, fault_addr_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic                hit;
    logic [SEL_W-1:0]    hit_idx;
    logic [31:0]         hit_off;
    logic [DATA_W-1:0]   sel_rdata;

    // Scanning from the top down lets the lowest matching window win
    // when windows overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int i = N_TARGETS - 1; i >= 0; i--) begin
            if ((addr >> SIZE_LOG2[i*5 +: 5]) ==
                (BASE_ADDRS[i*32 +: 32] >> SIZE_LOG2[i*5 +: 5])) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
                hit_off = addr & ((32'd1 << SIZE_LOG2[i*5 +: 5]) - 32'd1);
            end
        end
    end

    assign sel_rdata = t_rdata[int'(sel_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        addr_d        = addr_q;
        t_addr_d      = t_addr_q;
        t_wdata_d     = t_wdata_q;
        t_write_d     = t_write_q;
        t_funct3_d    = t_funct3_q;
        dataout_d     = dataout_q;
        fault_cause_d = fault_cause_q;
        fault_addr_d  = fault_addr_q;
        tmo_cnt_d     = tmo_cnt_q;

        if (ce) begin
            // Abort / end of access: status registers keep their values.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    addr_d        = addr;
                    t_wdata_d     = datain;
                    t_write_d     = memwrite;
                    t_funct3_d    = funct3;
                    fault_cause_d = CAUSE_NONE;
                    tmo_cnt_d     = '0;
                    if (hit) begin
                        sel_d    = hit_idx;
                        t_addr_d = hit_off;
                        state_d  = REQ;
                    end else begin
                        fault_cause_d = CAUSE_UNMAPPED;
                        fault_addr_d  = addr;
                        state_d       = FAULT;
                    end
                end
                REQ: begin
                    if (t_err[sel_q]) begin
                        fault_cause_d = CAUSE_TGT_ERR;
                        fault_addr_d  = addr_q;
                        state_d       = FAULT;
                    end else if (t_ack[sel_q]) begin
                        if (!t_write_q) begin
                            dataout_d = sel_rdata;
                        end
                        state_d = DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST)) begin
                        fault_cause_d = CAUSE_TIMEOUT;
                        fault_addr_d  = addr_q;
                        state_d       = FAULT;
                    end else if (tmo_cnt_q != {CNT_W{1'b1}}) begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                DONE:    state_d = DONE;
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            addr_q        <= '0;
            t_addr_q      <= '0;
            t_wdata_q     <= '0;
            t_write_q     <= 1'b0;
            t_funct3_q    <= '0;
            dataout_q     <= '0;
            fault_cause_q <= CAUSE_NONE;
            fault_addr_q  <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            addr_q        <= addr_d;
            t_addr_q      <= t_addr_d;
            t_wdata_q     <= t_wdata_d;
            t_write_q     <= t_write_d;
            t_funct3_q    <= t_funct3_d;
            dataout_q     <= dataout_d;
            fault_cause_q <= fault_cause_d;
            fault_addr_q  <= fault_addr_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    always_comb begin
        t_req = '0;
        if (state_q == REQ) begin
            t_req[sel_q] = 1'b1;
        end
    end

    assign busy         = (state_q == REQ) || ((state_q == IDLE) && !ce);
    assign valid        = (state_q == DONE) && !t_write_q;
    assign done         = (state_q == DONE);
    assign access_fault = (state_q == FAULT);
    assign dataout      = dataout_q;
    assign fault_cause  = fault_cause_q;
    assign fault_addr   = fault_addr_q;
    assign t_addr       = t_addr_q;
    assign t_wdata      = t_wdata_q;
    assign t_write      = t_write_q;
    assign t_funct3     = t_funct3_q;

endmodule

// File: doc/mmio_router.md
# mmio_router

Parametrised single-master memory-mapped I/O router sitting between the CPU load/store port and N peripheral targets (SPI SRAM, I2C, UART, timer, frequency generator, …). It replaces the hard-coded address decode with a table of base/size windows, drives a uniform req/ack handshake per target, and reports unmapped, target-error and timeout faults. Each new peripheral becomes a table entry rather than a router edit.

## Interface
Parameters:
- N_TARGETS, 4: number of target ports, 1..8.
- DATA_W, 32: data width.
- BASE_ADDRS, {0x00000000, 0x00800000, 0x00800040, 0x00800080}: packed N_TARGETS×32 window bases; entry i in bits [32i+31:32i].
- SIZE_LOG2, {23, 6, 6, 6}: packed N_TARGETS×5 window sizes as log2 bytes. BASE must be aligned to the window size.
- TIMEOUT_CYCLES, 1024: maximum cycles in REQ before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  access enable, active low. Falling to 0 starts an access; returning to 1 ends or aborts it.
- funct3  in  3  access size/sign, passed through to targets.
- addr  in  32  byte address.
- datain  in  DATA_W  write data.
- memwrite  in  1  1 = store, 0 = load.
- dataout  out  DATA_W  read data, registered.
- busy  out  1  access in progress.
- valid  out  1  load complete; dataout is valid.
- done  out  1  load or store complete without fault.
- access_fault  out  1  access faulted.
- fault_cause  out  2  0 none, 1 unmapped, 2 timeout, 3 target error.
- fault_addr  out  32  address of the most recent faulting access.
- t_req  out  N_TARGETS  one-hot request.
- t_addr  out  32  offset within the window: addr & ((1<<SIZE_LOG2[i])-1).
- t_wdata  out  DATA_W  registered datain.
- t_write  out  1  registered memwrite.
- t_funct3  out  3  registered funct3.
- t_ack  in  N_TARGETS  target completion.
- t_err  in  N_TARGETS  target error, qualified by the selected index only.
- t_rdata  in  N_TARGETS×DATA_W  packed target read data.

## Operation
- States: IDLE, REQ, DONE, FAULT.
- IDLE, ce=0:
  - Register addr, datain, memwrite and funct3.
  - Decode: hit_i = (addr >> SIZE_LOG2[i]) == (BASE_ADDRS[i] >> SIZE_LOG2[i]). The lowest hit index wins; overlapping windows are legal.
  - On a hit: store sel, go to REQ.
  - No hit: go to FAULT with cause 1 and capture fault_addr.
- REQ:
  - t_req[sel]=1; all other bits 0. t_addr, t_wdata, t_write and t_funct3 are stable.
  - t_err[sel] → FAULT, cause 3. t_err takes priority over t_ack in the same cycle.
  - t_ack[sel] → DONE. For a load, dataout ← t_rdata[sel].
  - Neither, and the timeout counter = TIMEOUT_CYCLES−1 with TIMEOUT_CYCLES≠0 → FAULT, cause 2. Ack in that same cycle wins.
  - Acks and errors on non-selected indices are ignored.
- DONE and FAULT hold until ce=1.
- ce=1 in any state → IDLE next cycle. t_req drops, which aborts any in-flight request; the target must tolerate the dropped request. dataout, fault_cause and fault_addr keep their values.
- fault_cause clears to 0 on the next access start (IDLE with ce=0). fault_addr is sticky until the next fault.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide, zeroed on entry to REQ, and never wraps.

## Timing
- Reset values: state IDLE; t_req=0; busy=valid=done=access_fault=0; fault_cause=0; dataout=0; fault_addr=0; t_addr=t_wdata=0; t_write=0; t_funct3=0.
- Reset asserted mid-access drops t_req on the next edge. Reset has priority over ce.
- busy = state==REQ || (state==IDLE && ce==0).
- valid = DONE && !t_write. done = DONE. access_fault = FAULT.
- Latency, with ce sampled low at edge 0:
  - t_req is high after edge 1.
  - If t_ack is already high during that cycle, DONE/valid is high after edge 2.
  - In general, completion = ack cycle + 1.
- Unmapped access: FAULT after edge 1; t_req never asserts.
- Timeout: t_req is high for exactly TIMEOUT_CYCLES cycles, then FAULT.
- Back-to-back accesses require ce=1 for at least one cycle between them.

## Test plan
Bench configuration: N_TARGETS=3; bases 0x0 / 0x00800000 / 0x00800040; sizes 23 / 6 / 6; TIMEOUT_CYCLES=16.
- Load 0x00800044; target 2 acks in its first REQ cycle with rdata 0xDEADBEEF → t_req=3'b100, t_addr=0x4, valid and dataout=0xDEADBEEF two cycles after ce falls.
- Store 0x00000010 with data 0x12345678; target 0 acks after 5 cycles → t_write=1, t_wdata=0x12345678, done high one cycle after ack, valid stays 0.
- Load 0x00900000 → FAULT after 1 cycle, fault_cause=1, fault_addr=0x00900000, t_req never high.
- Target 1 never acks → t_req high for exactly 16 cycles, then fault_cause=2. Repeat with ack in cycle 16 → DONE.
- Same-cycle t_ack and t_err on the selected target → fault_cause=3. t_ack on a non-selected index → ignored, still waiting.
- ce rises mid-REQ → t_req drops the next cycle, state IDLE. A subsequent access starts cleanly with fault_cause=0. Reset asserted mid-REQ → all outputs return to their reset values.
